// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC and the fetch-to-decode entry.
package core_pkg;
    localparam int WORD_LEN = 32;
    localparam int INST_BYTES = 4;
    localparam logic [WORD_LEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [WORD_LEN-1:0] pc;
        logic [WORD_LEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    // Flush dominates push and pop; a push at full is legal only alongside a pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem requests, {pc,inst} buffer to decode, redirect flush.
// Optional FETCH_BYPASS_EN: an empty buffer forwards a live response to decode in the same cycle.
module fetch_stage import core_pkg::INST_BYTES; #(
    parameter int WORD_LEN = core_pkg::WORD_LEN,
    parameter logic [WORD_LEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORD_LEN-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [WORD_LEN-1:0] imem_resp_inst,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [WORD_LEN-1:0] if_pc,
    output logic [WORD_LEN-1:0] if_inst,
    input  logic                redirect_valid,
    input  logic [WORD_LEN-1:0] redirect_pc,
    input  logic                halt
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int DROP_W = 16;

    logic [WORD_LEN-1:0]   fetch_pc;
    logic [DROP_W-1:0]     drop_cnt;
    logic [CNT_W-1:0]      inflight_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic [WORD_LEN-1:0]   inflight_head;
    logic [2*WORD_LEN-1:0] out_head;
    logic [CNT_W:0]        credits_used;
    logic                  req_fire;
    logic                  resp_live;
    logic                  resp_drop;
    logic                  out_valid;
    logic                  out_push;
    logic                  out_pop;
    logic                  bypass;

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid never depends on ready, and the imem response channel has no ready.
    assign credits_used   = {1'b0, inflight_cnt} + {1'b0, out_cnt};
    assign imem_req_valid = !rst && !halt && (credits_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop_cnt != '0);
    assign resp_live      = imem_resp_valid && (drop_cnt == '0);
    assign out_valid      = (out_cnt != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live && !out_valid && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_push = resp_live && !(bypass && if_ready);
    assign out_pop  = out_valid && if_ready;

    always_comb begin
        if_valid = out_valid || bypass;
        if_pc    = '0;
        if_inst  = '0;
        if (out_valid) begin
            if_pc   = out_head[2*WORD_LEN-1:WORD_LEN];
            if_inst = out_head[WORD_LEN-1:0];
        end else if (bypass) begin
            if_pc   = inflight_head;
            if_inst = imem_resp_inst;
        end
    end

    // Every request still owed by memory at redirect time becomes a drop; a response
    // arriving in the same cycle retires one of them immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~WORD_LEN'(3);
            drop_cnt <= drop_cnt + DROP_W'(inflight_cnt) + DROP_W'(req_fire)
                        - DROP_W'(imem_resp_valid);
        end else begin
            if (req_fire)  fetch_pc <= fetch_pc + WORD_LEN'(INST_BYTES);
            if (resp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
        end
    end

    sync_fifo #(.WIDTH(WORD_LEN), .DEPTH(FIFO_DEPTH)) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .head      (inflight_head),
        .count     (inflight_cnt)
    );

    sync_fifo #(.WIDTH(2*WORD_LEN), .DEPTH(FIFO_DEPTH)) u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (out_push),
        .push_data ({inflight_head, imem_resp_inst}),
        .pop       (out_pop),
        .head      (out_head),
        .count     (out_cnt)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order instruction memory model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] req_log[$];
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    int cyc = 0;
    int mem_lat = 1;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic void build_exp(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({base + 32'(4 * i), inst_of(base + 32'(4 * i))});
    endfunction

    // Memory answers each accepted request mem_lat cycles later; it forgets everything on reset.
    always @(posedge clk) begin
        cyc++;
        if (rst) mem_q.delete();
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        end
        if (!rst && if_valid && if_ready) got_q.push_back({if_pc, if_inst});
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic hold);
        rst = 1'b1;
        halt = hold;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat = lat;
        repeat (2) next_cycle();
        rst = 1'b0;
        req_log.delete();
        got_q.delete();
    endtask

    task automatic wait_reqs(input int n);
        for (int i = 0; i < 50 && req_log.size() < n; i++) begin
            next_cycle();
            sample();
        end
        n_tests++;
        if (req_log.size() < n) begin
            n_fail++;
            $display("FAIL wait_reqs: got %0d requests, expected %0d", req_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_inst = '0;
        next_cycle();
        sample();
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h expected 00000000", if_pc); end
        n_tests++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst: got %h expected 00000000", if_inst); end
    endtask

    task automatic test_basic();
        do_reset(1, 1'b0);
        sample();
        n_tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL basic_first_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr); end
        next_cycle(); sample();
        n_tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL basic_second_req: got %b/%h expected 1/00000004", imem_req_valid, imem_req_addr); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", if_valid); end
        next_cycle(); sample();
        n_tests++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, inst_of(32'h0)}) begin n_fail++; $display("FAIL basic_first_out: got %b/%h/%h expected 1/00000000/%h", if_valid, if_pc, if_inst, inst_of(32'h0)); end
        repeat (12) next_cycle();
        sample();
        n_tests++; if (got_q.size() < 6) begin n_fail++; $display("FAIL basic_count: got %0d expected >=6", got_q.size()); end
        build_exp(32'h0, got_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < req_log.size(); i++) begin
            n_tests++; if (req_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL basic_req[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        if_ready = 1'b0;
        repeat (8) next_cycle();
        sample();
        n_tests++; if (req_log.size() != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 2", req_log.size()); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        n_tests++; if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bp_head: got %b/%h expected 1/00000000", if_valid, if_pc); end
        next_cycle();
        if_ready = 1'b1;
        repeat (12) next_cycle();
        sample();
        n_tests++; if (got_q.size() < 5) begin n_fail++; $display("FAIL bp_resume_count: got %0d expected >=5", got_q.size()); end
        build_exp(32'h0, got_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(4, 1'b0);
        sample();
        wait_reqs(2);
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h10; sample();
        next_cycle(); redirect_valid = 1'b0; sample();
        n_tests++; if ({imem_req_addr, if_valid} !== {32'h10, 1'b0}) begin n_fail++; $display("FAIL rd_addr_10: got %h/%b expected 00000010/0", imem_req_addr, if_valid); end
        wait_reqs(4);
        n_tests++; if ({req_log[2], req_log[3]} !== {32'h10, 32'h14}) begin n_fail++; $display("FAIL rd_inflight: got %h %h expected 00000010 00000014", req_log[2], req_log[3]); end
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h103; sample();
        next_cycle(); redirect_valid = 1'b0; sample();
        n_tests++; if ({imem_req_addr, if_valid} !== {32'h100, 1'b0}) begin n_fail++; $display("FAIL rd_addr_100: got %h/%b expected 00000100/0", imem_req_addr, if_valid); end
        repeat (20) next_cycle();
        sample();
        n_tests++; if (got_q.size() < 3) begin n_fail++; $display("FAIL rd_count: got %0d expected >=3", got_q.size()); end
        build_exp(32'h100, got_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rd_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_redirect_collide();
        do_reset(1, 1'b0);
        sample();
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200; sample();
        n_tests++; if ({imem_req_valid, imem_req_ready, imem_resp_valid} !== 3'b111) begin n_fail++; $display("FAIL col_setup: got %b%b%b expected 111", imem_req_valid, imem_req_ready, imem_resp_valid); end
        next_cycle(); redirect_valid = 1'b0; sample();
        n_tests++; if ({imem_req_addr, if_valid} !== {32'h200, 1'b0}) begin n_fail++; $display("FAIL col_addr: got %h/%b expected 00000200/0", imem_req_addr, if_valid); end
        repeat (12) next_cycle();
        sample();
        n_tests++; if (req_log.size() < 4) begin n_fail++; $display("FAIL col_req_count: got %0d expected >=4", req_log.size()); end
        n_tests++; if ({req_log[0], req_log[1], req_log[2], req_log[3]} !== {32'h0, 32'h4, 32'h200, 32'h204}) begin n_fail++; $display("FAIL col_reqs: got %h %h %h %h expected 0 4 200 204", req_log[0], req_log[1], req_log[2], req_log[3]); end
        n_tests++; if (got_q.size() < 4) begin n_fail++; $display("FAIL col_count: got %0d expected >=4", got_q.size()); end
        build_exp(32'h200, got_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL col_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; sample();
        next_cycle(); redirect_valid = 1'b0; sample();
        n_tests++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_req_addr); end
        repeat (10) next_cycle();
        sample();
        n_tests++; if (req_log.size() < 3) begin n_fail++; $display("FAIL wrap_req_count: got %0d expected >=3", req_log.size()); end
        n_tests++; if ({req_log[1], req_log[2]} !== {32'hFFFF_FFFC, 32'h0}) begin n_fail++; $display("FAIL wrap_reqs: got %h %h expected fffffffc 00000000", req_log[1], req_log[2]); end
        n_tests++; if (got_q.size() < 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected >=2", got_q.size()); end
        n_tests++; if (got_q[0] !== {32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC)}) begin n_fail++; $display("FAIL wrap_out0: got %h expected %h", got_q[0], {32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC)}); end
        n_tests++; if (got_q[1] !== {32'h0, inst_of(32'h0)}) begin n_fail++; $display("FAIL wrap_out1: got %h expected %h", got_q[1], {32'h0, inst_of(32'h0)}); end
    endtask

    task automatic test_halt();
        do_reset(1, 1'b1);
        sample();
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_req_valid: got %b expected 0", imem_req_valid); end
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h41; sample();
        next_cycle(); redirect_valid = 1'b0; sample();
        n_tests++; if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h40}) begin n_fail++; $display("FAIL halt_redirect: got %b/%h expected 0/00000040", imem_req_valid, imem_req_addr); end
        n_tests++; if (req_log.size() != 0) begin n_fail++; $display("FAIL halt_no_req: got %0d expected 0", req_log.size()); end
        next_cycle(); halt = 1'b0; sample();
        n_tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL halt_resume: got %b/%h expected 1/00000040", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset(1, 1'b0);
        if_ready = 1'b0;
        repeat (5) next_cycle();
        sample();
        n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b expected 1", if_valid); end
        next_cycle(); rst = 1'b1; sample();
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
        next_cycle(); sample();
        n_tests++; if ({if_valid, if_pc, if_inst} !== {1'b0, 32'h0, 32'h0}) begin n_fail++; $display("FAIL mid_out: got %b/%h/%h expected 0/0/0", if_valid, if_pc, if_inst); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_addr: got %h expected 00000000", imem_req_addr); end
        next_cycle(); rst = 1'b0; if_ready = 1'b1; req_log.delete(); got_q.delete(); sample();
        n_tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL mid_restart: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr); end
        repeat (6) next_cycle();
        sample();
        n_tests++; if (got_q.size() < 1) begin n_fail++; $display("FAIL mid_count: got %0d expected >=1", got_q.size()); end
        n_tests++; if (got_q[0] !== {32'h0, inst_of(32'h0)}) begin n_fail++; $display("FAIL mid_first: got %h expected %h", got_q[0], {32'h0, inst_of(32'h0)}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
